// File: rtl/task_dispatcher_pkg.sv
// Purpose: shared types and defaults for the task dispatcher slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dispatch_pkg;

    localparam int TASK_WIDTH_DEFAULT     = 40;
    localparam int FIFO_ADDR_BITS_DEFAULT = 3;
    localparam int NUM_WORKERS_DEFAULT    = 4;

    typedef enum logic [0:0] {
        DISP_EMPTY = 1'b0,
        DISP_HOLD  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/task_dispatcher_if.sv
// Purpose: bundles the fifo-side and worker-side signals of the task dispatcher.
// Latency: n/a (wires only).
// Backpressure: task_ready per worker; fifo_ren pops the fwft fifo head.
// Ports: master = dispatcher side, slave = fifo/worker environment side.
//   fifo_count/fifo_rdata -> dispatcher, fifo_ren -> fifo,
//   task_valid/task_data -> workers, task_ready -> dispatcher, idle -> monitor.
interface task_dispatcher_if #(
    parameter int WIDTH       = 40,
    parameter int ADDR_BITS   = 3,
    parameter int NUM_WORKERS = 4
);
    logic [ADDR_BITS:0]     fifo_count;
    logic [WIDTH-1:0]       fifo_rdata;
    logic                   fifo_ren;
    logic [NUM_WORKERS-1:0] task_valid;
    logic [WIDTH-1:0]       task_data;
    logic [NUM_WORKERS-1:0] task_ready;
    logic                   idle;

    modport master (
        input  fifo_count, fifo_rdata, task_ready,
        output fifo_ren, task_valid, task_data, idle
    );

    modport slave (
        output fifo_count, fifo_rdata, task_ready,
        input  fifo_ren, task_valid, task_data, idle
    );
endinterface

// File: rtl/task_dispatcher_rr_pick.sv
// Purpose: round-robin pick of the first unmasked requester after last_i.
// Latency: combinational.
// Backpressure: none; grant_vld_o low when no eligible requester.
// Ports: req_i requests, mask_i excluded requesters, last_i previous grant,
//   grant_vld_o a pick exists, grant_idx_o picked index.
module rr_pick #(
    parameter  int N  = 4,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [LW-1:0] last_i,
    output logic          grant_vld_o,
    output logic [LW-1:0] grant_idx_o
);
    logic [LW-1:0] cand;

    // Scan last+1, last+2, ... last+N (mod N); last itself is checked last.
    always_comb begin
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = LW'((int'(last_i) + k) % N);
            if (!grant_vld_o && req_i[cand] && !mask_i[cand]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = cand;
            end
        end
    end
endmodule

// File: rtl/task_dispatcher.sv
// Purpose: drains a fwft task fifo into a one-entry slot offered round-robin to N workers.
// Latency: fifo head present -> task_valid high one clock later; 1 task/cycle sustained.
// Backpressure: slot held until the owner accepts; fifo only popped when the slot frees.
// Ports: clock, reset (sync, active-high); bus (master modport) carries the fifo and
//   worker handshakes plus idle. Optional stats outputs dispatch_total/stall_cycles exist
//   only when TASK_DISPATCHER_STATS_EN is defined.
module task_dispatcher
    import dispatch_pkg::*;
#(
    parameter int WIDTH       = TASK_WIDTH_DEFAULT,
    parameter int ADDR_BITS   = FIFO_ADDR_BITS_DEFAULT,
    parameter int NUM_WORKERS = NUM_WORKERS_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    task_dispatcher_if.master bus
`ifdef TASK_DISPATCHER_STATS_EN
    ,
    output logic [31:0] dispatch_total,
    output logic [31:0] stall_cycles
`endif
);
    localparam int LW = $clog2(NUM_WORKERS);
    localparam logic [0:0] ST_EMPTY = DISP_EMPTY;
    localparam logic [0:0] ST_HOLD  = DISP_HOLD;

    logic [0:0]             state_q, state_d;
    logic [LW-1:0]          owner_q, owner_d;
    logic [LW-1:0]          last_q, last_d;
    logic [WIDTH-1:0]       data_q, data_d;

    logic [NUM_WORKERS-1:0] owner_oh;
    logic                   hold;
    logic                   xfer;
    logic                   load;
    logic                   pick_vld;
    logic [LW-1:0]          pick_idx;

    assign hold     = (state_q == ST_HOLD);
    assign owner_oh = NUM_WORKERS'(1) << owner_q;
    assign xfer     = hold && bus.task_ready[owner_q];

    // In HOLD the current owner is masked so a same-cycle reload goes elsewhere;
    // last_q equals owner_q there, so the scan still starts just after the owner.
    rr_pick #(.N(NUM_WORKERS)) u_pick (
        .req_i       (bus.task_ready),
        .mask_i      (hold ? owner_oh : '0),
        .last_i      (last_q),
        .grant_vld_o (pick_vld),
        .grant_idx_o (pick_idx)
    );

    // Reset gates the pop so a word is never lost to a load that reset discards.
    assign load = !reset && (bus.fifo_count != '0) && pick_vld && (!hold || xfer);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            state_d = ST_HOLD;
            owner_d = pick_idx;
            last_d  = pick_idx;
            data_d  = bus.fifo_rdata;
        end else if (xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            owner_q <= '0;
            last_q  <= LW'(NUM_WORKERS - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign bus.fifo_ren   = load;
    assign bus.task_valid = hold ? owner_oh : '0;
    assign bus.task_data  = data_q;
    assign bus.idle       = !hold && (bus.fifo_count == '0);

`ifdef TASK_DISPATCHER_STATS_EN
    logic [31:0] total_q;
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            total_q <= '0;
            stall_q <= '0;
        end else begin
            if (xfer && total_q != 32'hFFFF_FFFF) begin
                total_q <= total_q + 32'd1;
            end
            if (hold && !bus.task_ready[owner_q] && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign dispatch_total = total_q;
    assign stall_cycles   = stall_q;
`endif
endmodule

// File: tb/tb_task_dispatcher.sv
// Purpose: self-checking bench for task_dispatcher with a queue-based fifo and reference model.
// Latency: n/a.
// Backpressure: worker readies driven by directed vectors, then pseudo-random.
module tb_task_dispatcher;
    localparam int W  = 40;
    localparam int AB = 3;
    localparam int NW = 4;

    logic clock;
    logic reset;

    task_dispatcher_if #(.WIDTH(W), .ADDR_BITS(AB), .NUM_WORKERS(NW)) bus ();

`ifdef TASK_DISPATCHER_STATS_EN
    logic [31:0] dispatch_total;
    logic [31:0] stall_cycles;
`endif

    task_dispatcher #(.WIDTH(W), .ADDR_BITS(AB), .NUM_WORKERS(NW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef TASK_DISPATCHER_STATS_EN
        ,
        .dispatch_total (dispatch_total),
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic         pop_pending = 1'b0;

    // reference model state
    logic         m_known = 1'b0;
    logic         m_full  = 1'b0;
    int           m_owner = 0;
    int           m_last  = NW - 1;
    logic [W-1:0] m_data  = '0;
    logic [31:0]  m_total = '0;
    logic [31:0]  m_stall = '0;
    int           p;
    logic         xfer_m, take_m;
    logic [NW-1:0] ev;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // First ready worker after 'last' in circular order, never 'excl'; -1 if none.
    function automatic int pick(input logic [NW-1:0] rdy, input int last, input int excl);
        for (int k = 1; k <= NW; k++) begin
            int w;
            w = (last + k) % NW;
            if (w != excl && rdy[w]) return w;
        end
        return -1;
    endfunction

    task automatic drive_fifo();
        bus.fifo_count = (AB + 1)'(q.size());
        bus.fifo_rdata = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (pop_pending && q.size() > 0) q.delete(0);
        drive_fifo();
    endtask

    // Model: one slot, round-robin hand-out, outputs checked on every falling edge.
    always @(negedge clock) begin
        if (m_known) begin
            ev = m_full ? (NW'(1) << m_owner) : '0;
            chk("mdl_valid", 64'(bus.task_valid), 64'(ev));
            chk("mdl_data", 64'(bus.task_data), 64'(m_data));
            chk("mdl_idle", 64'(bus.idle), 64'(!m_full && q.size() == 0));
`ifdef TASK_DISPATCHER_STATS_EN
            chk("mdl_total", 64'(dispatch_total), 64'(m_total));
            chk("mdl_stall", 64'(stall_cycles), 64'(m_stall));
`endif
        end
        p      = pick(bus.task_ready, m_last, m_full ? m_owner : -1);
        xfer_m = m_full && bus.task_ready[m_owner];
        take_m = !reset && q.size() != 0 && (!m_full || xfer_m) && p >= 0;
        if (m_known) chk("mdl_ren", 64'(bus.fifo_ren), 64'(take_m));
        pop_pending = bus.fifo_ren;
        if (reset) begin
            m_known = 1'b1;
            m_full  = 1'b0;
            m_owner = 0;
            m_last  = NW - 1;
            m_data  = '0;
            m_total = '0;
            m_stall = '0;
        end else begin
            if (xfer_m && m_total != 32'hFFFF_FFFF) m_total = m_total + 1;
            if (m_full && !bus.task_ready[m_owner] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (take_m) begin
                m_full  = 1'b1;
                m_owner = p;
                m_last  = p;
                m_data  = q[0];
            end else if (xfer_m) begin
                m_full = 1'b0;
            end
        end
    end

    logic [W-1:0] wa, wb, wc, wx, wd, we, wf, wg, wh, wj;
    logic [W-1:0] t2_dat [3];
    logic [NW-1:0] t2_vld [3];
    logic t2_ren [3];

    initial begin
        wa = 40'hA0_0000_0001; wb = 40'hB0_0000_0002; wc = 40'hC0_0000_0003;
        wx = 40'h55_1234_5678; wd = 40'hD0_0000_0004; we = 40'hE0_0000_0005;
        wf = 40'hF0_0000_0006; wg = 40'h60_0000_0007; wh = 40'h70_0000_0008;
        wj = 40'h80_0000_0009;
        t2_dat[0] = wa; t2_dat[1] = wb; t2_dat[2] = wc;
        t2_vld[0] = 4'b0001; t2_vld[1] = 4'b0010; t2_vld[2] = 4'b0100;
        t2_ren[0] = 1'b1; t2_ren[1] = 1'b1; t2_ren[2] = 1'b0;

        reset = 1'b1;
        bus.task_ready = '0;
        drive_fifo();
        tick();
        tick();
        reset = 1'b0;

        // 1: empty fifo, everyone ready
        bus.task_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t1_ren", 64'(bus.fifo_ren), 64'd0);
            chk("t1_valid", 64'(bus.task_valid), 64'd0);
            chk("t1_idle", 64'(bus.idle), 64'd1);
            chk("t1_data", 64'(bus.task_data), 64'd0);
            tick();
        end

        // 2: three words to workers 0,1,2 back to back
        q.push_back(wa); q.push_back(wb); q.push_back(wc);
        drive_fifo();
        @(negedge clock);
        chk("t2_ren0", 64'(bus.fifo_ren), 64'd1);
        chk("t2_valid0", 64'(bus.task_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clock);
            chk("t2_valid", 64'(bus.task_valid), 64'(t2_vld[i]));
            chk("t2_data", 64'(bus.task_data), 64'(t2_dat[i]));
            chk("t2_ren", 64'(bus.fifo_ren), 64'(t2_ren[i]));
        end

        // 3: X to worker 1, held through five stalled cycles
        tick();
        q.push_back(wx);
        bus.task_ready = 4'b0010;
        drive_fifo();
        @(negedge clock);
        chk("t3_ren", 64'(bus.fifo_ren), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.task_ready = 4'b1101;
            @(negedge clock);
            chk("t3_valid", 64'(bus.task_valid), 64'b0010);
            chk("t3_data", 64'(bus.task_data), 64'(wx));
        end
        tick();
        bus.task_ready = 4'b0010;
        @(negedge clock);
        chk("t3_valid_acc", 64'(bus.task_valid), 64'b0010);
`ifdef TASK_DISPATCHER_STATS_EN
        chk("t3_stall", 64'(stall_cycles), 64'd5);
        chk("t3_total", 64'(dispatch_total), 64'd3);
`endif
        tick();
        bus.task_ready = 4'b0000;
        @(negedge clock);
        chk("t3_valid_after", 64'(bus.task_valid), 64'd0);
        chk("t3_idle", 64'(bus.idle), 64'd1);

        // 4: no ready workers, then worker 2 ready
        tick();
        q.push_back(wd); q.push_back(we);
        drive_fifo();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("t4_ren_blk", 64'(bus.fifo_ren), 64'd0);
            chk("t4_valid_blk", 64'(bus.task_valid), 64'd0);
            chk("t4_idle_blk", 64'(bus.idle), 64'd0);
            tick();
        end
        bus.task_ready = 4'b0100;
        @(negedge clock);
        chk("t4_ren", 64'(bus.fifo_ren), 64'd1);
        tick();
        @(negedge clock);
        chk("t4_valid", 64'(bus.task_valid), 64'b0100);
        chk("t4_data", 64'(bus.task_data), 64'(wd));
        chk("t4_noreload", 64'(bus.fifo_ren), 64'd0);
        tick();
        @(negedge clock);
        chk("t4_gap", 64'(bus.task_valid), 64'd0);
        tick();
        @(negedge clock);
        chk("t4_valid2", 64'(bus.task_valid), 64'b0100);
        chk("t4_data2", 64'(bus.task_data), 64'(we));
        tick();
        bus.task_ready = 4'b0000;

        // 5: only worker 3 ready, owner exclusion forces a bubble
        tick();
        q.push_back(wf); q.push_back(wg);
        bus.task_ready = 4'b1000;
        drive_fifo();
        @(negedge clock);
        chk("t5_ren0", 64'(bus.fifo_ren), 64'd1);
        tick();
        @(negedge clock);
        chk("t5_valid1", 64'(bus.task_valid), 64'b1000);
        chk("t5_data1", 64'(bus.task_data), 64'(wf));
        chk("t5_ren1", 64'(bus.fifo_ren), 64'd0);
        tick();
        @(negedge clock);
        chk("t5_valid_gap", 64'(bus.task_valid), 64'd0);
        chk("t5_ren_gap", 64'(bus.fifo_ren), 64'd1);
        tick();
        @(negedge clock);
        chk("t5_valid2", 64'(bus.task_valid), 64'b1000);
        chk("t5_data2", 64'(bus.task_data), 64'(wg));
        tick();
        bus.task_ready = 4'b0000;

        // 6: reset while holding H; next grant restarts at worker 0
        tick();
        q.push_back(wh);
        bus.task_ready = 4'b0001;
        drive_fifo();
        @(negedge clock);
        chk("t6_ren", 64'(bus.fifo_ren), 64'd1);
        tick();
        bus.task_ready = 4'b0000;
        @(negedge clock);
        chk("t6_hold", 64'(bus.task_valid), 64'b0001);
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_ren_rst", 64'(bus.fifo_ren), 64'd0);
        tick();
        reset = 1'b0;
        bus.task_ready = 4'b1111;
        q.push_back(wj);
        drive_fifo();
        @(negedge clock);
        chk("t6_valid_rst", 64'(bus.task_valid), 64'd0);
        chk("t6_ren_after", 64'(bus.fifo_ren), 64'd1);
`ifdef TASK_DISPATCHER_STATS_EN
        chk("t6_total", 64'(dispatch_total), 64'd0);
`endif
        tick();
        @(negedge clock);
        chk("t6_grant0", 64'(bus.task_valid), 64'b0001);
        chk("t6_data", 64'(bus.task_data), 64'(wj));

        // pseudo-random traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            tick();
            if (q.size() < 6 && $urandom_range(0, 2) != 0) begin
                q.push_back({8'h5A, 32'($urandom)});
                drive_fifo();
            end
            bus.task_ready = NW'($urandom);
        end
        tick();
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
